switch_injector: RTL
====================

// Module: switch_injector
// PURPOSE
//  Board-level stimulus source, the transmit end of the 8-bit valid/ready debug stream that the LED display debugger consumes.
//  On a debounced press of button_submit, captures switches[7:0] and emits one byte, or a burst of BURST_LENGTH bytes, into an internal FIFO.
//  The FIFO drains onto out_data/out_valid/out_ready for hand-driven testing of downstream pipelines on the Basys board.
// PARAMETERS
//  MAX_QUEUE_DEPTH_BITS  8   log2 of FIFO depth (FIFO holds 2**N bytes)
//  BURST_LENGTH          16  bytes per burst, legal range 1..256
// PORTS
//  clock            in   1  single system clock
//  reset            in   1  synchronous, active-high
//  switches         in   8  byte value sampled on a submit press
//  burst_mode       in   1  sampled on press: 1 = burst, 0 = single byte
//  button_submit    in   1  raw push button, asynchronous and bouncy
//  out_data         out  8  stream data (FIFO head)
//  out_valid        out  1  stream valid
//  out_ready        in   1  stream ready from consumer
//  submitted_count  out  8  bytes accepted by FIFO, wraps 255->0
//  dropped          out  1  sticky: a press was ignored because the block was busy
//  busy             out  1  FSM not IDLE
// BEHAVIOUR
//  - Reset values: out_valid=0 (FIFO emptied), submitted_count=0, dropped=0, busy=0, FSM=IDLE.
//  - Button path: raw button -> debouncer -> prev register.
//    - prev register resets to 1, so a button held through reset never yields a press.
//    - press = debounced & !prev; it is a 1-cycle pulse.
//  - FSM states IDLE, SEND (2 states):
//    - IDLE, press at cycle N: base<=switches, idx<=0, last<=(burst_mode ? BURST_LENGTH-1 : 0); SEND from N+1.
//    - SEND: FIFO in_valid=1, in_data=base+idx (8-bit, wraps 0xFF->0x00).
//    - Handshake (in_valid & in_ready): submitted_count++; then if idx==last go IDLE, else idx++.
//    - in_valid is held while in_ready=0 (stall, no data loss); in_data stable during a stall.
//    - Minimum gap: one IDLE cycle between bursts.
//  - Press while SEND: ignored, dropped<=1 next cycle; cleared only by reset.
//  - busy = (state==SEND), registered from FSM state, no combinational path from inputs.
//  - Output side: out_* connect directly to FIFO out_*; standard valid/ready rules.
//    - Data transfers only when out_valid & out_ready.
//    - out_data is stable while out_valid=1 and out_ready=0.
//  - Latency: press pulse at N -> FIFO write earliest N+1 -> out_valid per FIFO read latency.
//  - idx width: 8 bits; BURST_LENGTH=256 emits base..base+255, every byte value once.
//  - Reset mid-burst: FSM->IDLE, remaining bytes abandoned, FIFO contents discarded.
//  - Simultaneous press and final handshake in SEND: press is dropped (state still SEND that cycle).
// STRUCTURE
//  - Reuses codebase fifo (DATA_WIDTH=8, MAX_DEPTH_BITS) and debouncer (no reset port).
//  - One new sub-module: rising_edge_detector (clock, reset, in, pulse; prev reset value parameter RESET_PREV).
//  - FSM state encodings are localparams inside this module.
//  - DEBUG_DATA_WIDTH=8 goes in the shared debug defines include, alongside the LED debugger.
//  - Estimated size ~150 lines plus the sub-module.
// TESTING (debouncer stubbed or bypassed via a short-count param in the bench)
//  1. switches=0x3C, burst_mode=0, one press, out_ready=1:
//     exactly one byte 0x3C on out; submitted_count=1; busy high for 1 cycle.
//  2. switches=0xFE, burst_mode=1, BURST_LENGTH=4, out_ready=1:
//     out bytes FE,FF,00,01 in order; submitted_count=4.
//  3. MAX_QUEUE_DEPTH_BITS=2, burst of 16, out_ready=0:
//     FSM stalls at FIFO full, out_data=first byte stable.
//     Then out_ready=1: all 16 bytes arrive, none lost or duplicated.
//  4. Second press during an active burst:
//     dropped=1 next cycle and stays 1; burst contents unchanged.
//     A later press after IDLE works.
//  5. Reset asserted mid-burst with button held high:
//     outputs return to reset values; no burst starts after release until button released and re-pressed.
//  6. 300 single presses with a draining consumer:
//     submitted_count wraps to 44; every byte received matches switches at its press.

Source files
------------

// File: rtl/switch_injector_pkg.sv
// Shared types for the switch-driven debug stream injector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package switch_injector_pkg;

  // Width of the debug byte stream shared with the LED display debugger.
  localparam int DEBUG_DATA_WIDTH = 8;

  typedef logic [DEBUG_DATA_WIDTH-1:0] dbg_byte_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_t;

  // Index of the final byte of a press: 0 for a single byte, len-1 for a burst.
  function automatic dbg_byte_t burst_last(input logic burst, input int burst_len);
    return burst ? dbg_byte_t'(burst_len - 1) : '0;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Synchronises a raw push button and accepts a new level once stable long enough.
// Latency: 2 sync cycles plus DEBOUNCE_CYCLES of stable input.
// Backpressure: none.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] count;
  logic          stable;

  assign out = stable;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock) begin
    sync <= {sync[0], in};
  end

  // Any bounce back to the accepted level restarts the stability count.
  always_ff @(posedge clock) begin
    if (sync[1] == stable) begin
      count <= '0;
    end else if (count == LAST) begin
      stable <= sync[1];
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo.sv
// Generic show-ahead FIFO of 2**MAX_DEPTH_BITS entries.
// Latency: a write at cycle N is visible on out_valid/out_data at N+1.
// Backpressure: in_ready drops only when full; head holds while out_ready=0.
module fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_COUNT = {1'b1, {MAX_DEPTH_BITS{1'b0}}};

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      push;
  logic                      pop;

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rising_edge_detector.sv
// One-cycle pulse on each 0->1 transition of a clean level.
// Latency: combinational pulse in the cycle the level rises.
// Backpressure: none.
module rising_edge_detector #(
  parameter logic RESET_PREV = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev;

  assign pulse = in & ~prev;

  // Previous level; a preset of 1 hides a level already high at reset.
  always_ff @(posedge clock) begin
    if (reset) prev <= RESET_PREV;
    else       prev <= in;
  end

endmodule

// File: rtl/switch_injector.sv
// Pushes the switch byte (or an incrementing burst) into a FIFO on each button press.
// Latency: press at N -> FIFO write from N+1 -> out_valid at N+2 at the earliest.
// Backpressure: FSM holds in_valid/data while FIFO full; presses during SEND are dropped.
module switch_injector
  import switch_injector_pkg::*;
#(
  parameter int MAX_QUEUE_DEPTH_BITS = 8,
  parameter int BURST_LENGTH         = 16,
  parameter int DEBOUNCE_CYCLES      = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] switches,
  input  logic       burst_mode,
  input  logic       button_submit,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] submitted_count,
  output logic       dropped,
  output logic       busy
);

  logic       button_db;
  logic       press;
  inj_state_t state_q, state_d;
  dbg_byte_t  base_q, base_d;
  dbg_byte_t  idx_q, idx_d;
  dbg_byte_t  last_q, last_d;
  dbg_byte_t  count_q, count_d;
  logic       dropped_q, dropped_d;
  logic       fifo_in_vld;
  logic       fifo_in_rdy;
  dbg_byte_t  fifo_in_dat;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock(clock),
    .in   (button_submit),
    .out  (button_db)
  );

  rising_edge_detector #(
    .RESET_PREV(1'b1)
  ) u_edge (
    .clock(clock),
    .reset(reset),
    .in   (button_db),
    .pulse(press)
  );

  fifo #(
    .DATA_WIDTH    (DEBUG_DATA_WIDTH),
    .MAX_DEPTH_BITS(MAX_QUEUE_DEPTH_BITS)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .in_data  (fifo_in_dat),
    .in_valid (fifo_in_vld),
    .in_ready (fifo_in_rdy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign fifo_in_dat     = base_q + idx_q;
  assign submitted_count = count_q;
  assign dropped         = dropped_q;
  assign busy            = (state_q == ST_SEND);

  // FSM state and burst bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state: latch the press in IDLE, walk idx through the burst in SEND.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    last_d      = last_q;
    count_d     = count_q;
    dropped_d   = dropped_q;
    fifo_in_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          base_d  = switches;
          idx_d   = '0;
          last_d  = burst_last(burst_mode, BURST_LENGTH);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        fifo_in_vld = 1'b1;
        // A press landing on the final handshake still counts as busy.
        if (press) dropped_d = 1'b1;
        if (fifo_in_rdy) begin
          count_d = count_q + 8'd1;
          if (idx_q == last_q) state_d = ST_IDLE;
          else                 idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
